// File: rtl/spi_master.sv
// rtl/spi_master.sv - 10-bit command SPI initiator sharing clk with the slave, with read-back of one byte
module spi_master #(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_CMD,
        S_SHIFT,
        S_WAIT,
        S_READ,
        S_STOP
    } state_t;

    // Reload values: each timed state runs until its down-counter hits zero.
    localparam logic [3:0] SHIFT_LOAD = 4'd9;
    localparam logic [3:0] READ_LOAD  = 4'd7;
    localparam logic [3:0] WAIT_LOAD  = 4'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
    localparam logic [3:0] STOP_LOAD  = 4'(GAP - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [9:0] cmd_q;
    logic [7:0] rd_shift_q;
    logic       mosi_d;
    logic       is_rd_data;
    logic       last_read;

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = !cmd_ready;
    assign is_rd_data = (cmd_q[9:8] == 2'b11);
    assign last_read  = (state_q == S_READ) && (cnt_q == 4'd0);

    // Next-state, counter reload and the MOSI value the next state will present
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mosi_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_CMD;
            end
            S_CMD: begin
                state_d = S_SHIFT;
                cnt_d   = SHIFT_LOAD;
            end
            S_SHIFT: begin
                if (cnt_q == 4'd0) begin
                    if (!is_rd_data) begin
                        state_d = S_STOP;
                        cnt_d   = STOP_LOAD;
                    end else if (RD_WAIT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_READ;
                        cnt_d   = READ_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_READ;
                    cnt_d   = READ_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_STOP;
                    cnt_d   = STOP_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // The command bit in CMD is the op MSB; SHIFT walks the word MSB first.
        if (state_d == S_CMD) begin
            mosi_d = cmd_q[9];
        end else if (state_d == S_SHIFT) begin
            mosi_d = cmd_q[cnt_d];
        end
    end

    // State, counter and latched command word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cmd_ready && cmd_valid) begin
                cmd_q <= cmd_data;
            end
        end
    end

    // Registered pins: driven from the next state so SS_n falls the cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            SS_n <= 1'b1;
            MOSI <= 1'b0;
        end else begin
            SS_n <= (state_d == S_IDLE) || (state_d == S_STOP);
            MOSI <= mosi_d;
        end
    end

    // MISO capture during READ only; result and strobe published on the last sample
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_shift_q <= 8'd0;
            rd_data    <= 8'd0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= last_read;
            if (state_q == S_READ) begin
                rd_shift_q <= {rd_shift_q[6:0], MISO};
            end
            if (last_read) begin
                rd_data <= {rd_shift_q[6:0], MISO};
            end
        end
    end

endmodule
